lvds_rx_deser: RTL and testbench
================================

# lvds_rx_deser

Soft-logic LVDS receive deserializer and word aligner, the receive end of the 8-bit LVDS serial link driven by the `lvds_test` transmitter. It samples the serial line once per bit clock, hunts for the byte boundary using a repeated training word, bit-slips until that word is framed correctly, and after lock emits one parallel byte per 8 bit times. It replaces the hard-IP `rx_data_align`/`rx_locked` path on devices without a hard deserializer.

## Interface
Parameters:
- `DATA_W`, 8: word width; the bit and slip counters are 3 bits wide.
- `TRAIN_PATTERN`, 8'hF1: training word. It must be rotation-unique, meaning all 8 rotations are distinct. 8'hF1 satisfies this.
- `LOCK_CNT`, 4: number of consecutive framed matches required for lock, from 1 to 15.

Ports:
- `clk` in 1: bit clock. One serial bit is sampled per rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_in` in 1: serial data, MSB first, synchronous to `clk`.
- `rx_data_align` in 1: synchronous level. Its rising edge forces a re-hunt.
- `rx_data` out 8: last framed word. Updated only at a word boundary.
- `rx_valid` out 1: one-cycle strobe, asserted only in LOCKED and only at a word boundary.
- `rx_locked` out 1: high while the state is LOCKED.

## Operation
- Shift register: `sr_next = {sr[6:0], rx_in}`; `sr <= sr_next` on every edge.
- Bit counter `bit_cnt` counts 0 to 7 and wraps to 0.
  - A word boundary is any edge where `bit_cnt == 7` and no slip is pending.
  - Only at a boundary is `sr_next` compared with `TRAIN_PATTERN`, or output.
- Slip: on a compare mismatch in HUNT or VERIFY, `bit_cnt` holds its value for exactly one edge.
  - The next boundary therefore occurs 9 edges later, so the frame moves one bit later.
  - Slips accumulate mod 8. Once the frame is correct, no further slips occur.
- FSM with three states: HUNT, VERIFY, LOCKED.
  - HUNT, boundary, match: go to VERIFY with `match_cnt = 1`. If `LOCK_CNT == 1`, go directly to LOCKED.
  - HUNT, boundary, mismatch: slip and stay in HUNT.
  - VERIFY, boundary, match: `match_cnt++`. When it reaches `LOCK_CNT`, go to LOCKED.
  - VERIFY, boundary, mismatch: slip, go to HUNT, `match_cnt = 0`.
  - LOCKED: at every boundary, `rx_data <= sr_next` and `rx_valid <= 1`. No pattern checking is done; payload is arbitrary.
  - Any state, on a rising edge of `rx_data_align` (detected as the registered previous value is 0 and the current value is 1): go to HUNT, clear `match_cnt`, and suppress `rx_valid` on that edge. `bit_cnt` is not reset.
- If a rising edge of `rx_data_align` and a boundary occur on the same edge, the align edge wins: no `rx_valid` and no `match_cnt` change.
- Reset values:
  - `rx_data = 0`, `rx_valid = 0`, `rx_locked = 0`.
  - `sr = 0`, `bit_cnt = 0`, `match_cnt = 0`, state = HUNT, registered `rx_data_align` = 0.
- Reset asserted mid-word clears everything immediately (asynchronous). Deassertion is not re-synchronized inside this block.

## Timing
- The first edge after reset release samples bit 0. That edge is at `bit_cnt == 0`, so the first boundary is the 8th edge after release.
- Latency: the last bit of a word, sampled on edge k, is in `rx_data` with `rx_valid` high immediately after edge k.
- `rx_locked` rises after the edge on which the `LOCK_CNT`-th consecutive framed match is seen. The first `rx_valid` follows at the next boundary, 8 edges later.
- A stream carrying the pattern with a frame offset of s bits (s from 0 to 7) locks within (s + LOCK_CNT) × 8 + s edges of the first boundary.
- `rx_locked` falls one edge after a rising edge of `rx_data_align`.

## Configuration
- `LVDS_RX_SLIP_POS_EN` defined:
  - Adds output port `rx_slip_pos` (out, 3 bits), the number of slips mod 8 since the last reset or re-hunt.
  - It is cleared on reset and on a rising edge of `rx_data_align`, and holds its value while LOCKED.
- Not defined: the port and its counter are absent, and all other behaviour is identical.

## Test plan
- Reset: hold `rst_n = 0` while `rx_in` toggles. Required: `rx_data = 8'h00`, `rx_valid = 0`, `rx_locked = 0` throughout; drive `rst_n` low again mid-word and confirm all outputs clear with no clock edge.
- Aligned lock: starting at the first edge after release, send 4× 8'hF1 then 8'h22, 8'hF1, 8'h22. Required: `rx_locked` is high after edge 32; `rx_valid` pulses after edges 40, 48, 56 with `rx_data` 8'h22, 8'hF1, 8'h22.
- Offset lock: prefix 3 zero bits, then repeated 8'hF1. Required: exactly 3 slips (`rx_slip_pos = 3` with the macro defined), then lock after 4 matches and `rx_valid` data equal to 8'hF1 every 8 edges.
- Broken verify: send aligned 8'hF1, 8'hF1, 8'hF0, then 8'hF1 continuously. Required: the state returns to HUNT at the third boundary and `rx_locked` stays 0 until 4 consecutive framed matches are seen after realignment.
- Re-hunt: while locked, pulse `rx_data_align` from 0 to 1 for one cycle and keep it high. Required: `rx_locked = 0` on the next edge, no `rx_valid` on that edge, and relock after 4 further 8'hF1 words.
- Simultaneous events: raise `rx_data_align` on a boundary edge while locked. Required: no `rx_valid` on that edge and the state is HUNT afterwards.

Source files
------------

// File: rtl/lvds_rx_deser.sv
// LVDS receive deserializer and word aligner: samples one bit per clk, bit-slips onto a training word, then emits framed bytes.
// Optional feature macro: LVDS_RX_SLIP_POS_EN adds the rx_slip_pos output (slips mod 8 since reset/re-hunt).
module lvds_rx_deser #(
    parameter int                DATA_W        = 8,
    parameter logic [DATA_W-1:0] TRAIN_PATTERN = 8'hF1,
    parameter int                LOCK_CNT      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_in,
    input  logic              rx_data_align,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_locked
`ifdef LVDS_RX_SLIP_POS_EN
    ,
    output logic [2:0]        rx_slip_pos
`endif
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [2:0] BIT_LAST = 3'(DATA_W - 1);
    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

    state_t            state_r;
    state_t            state_s;
    logic [DATA_W-1:0] sr_r;
    logic [DATA_W-1:0] sr_next_s;
    logic [2:0]        bit_cnt_r;
    logic              slip_pend_r;
    logic [3:0]        match_cnt_r;
    logic [3:0]        match_cnt_s;
    logic              align_d_r;
    logic              align_rise_s;
    logic              boundary_s;
    logic              match_s;
    logic              slip_s;
    logic [DATA_W-1:0] data_s;
    logic              valid_s;

    assign sr_next_s    = {sr_r[DATA_W-2:0], rx_in};
    assign align_rise_s = rx_data_align & ~align_d_r;
    // A slip holds bit_cnt at its last value for one edge, so that edge is not a boundary.
    assign boundary_s   = (bit_cnt_r == BIT_LAST) & ~slip_pend_r;
    assign match_s      = (sr_next_s == TRAIN_PATTERN);

    // Next-state, match counting, slip request and output word selection.
    always_comb begin
        state_s     = state_r;
        match_cnt_s = match_cnt_r;
        slip_s      = 1'b0;
        data_s      = rx_data;
        valid_s     = 1'b0;
        if (align_rise_s) begin
            state_s     = HUNT;
            match_cnt_s = 4'd0;
        end else if (boundary_s) begin
            case (state_r)
                HUNT: begin
                    if (match_s) begin
                        match_cnt_s = 4'd1;
                        state_s     = (LOCK_TGT == 4'd1) ? LOCKED : VERIFY;
                    end else begin
                        slip_s = 1'b1;
                    end
                end
                VERIFY: begin
                    if (match_s) begin
                        match_cnt_s = match_cnt_r + 4'd1;
                        if (match_cnt_s == LOCK_TGT) begin
                            state_s = LOCKED;
                        end else begin
                            state_s = VERIFY;
                        end
                    end else begin
                        slip_s      = 1'b1;
                        state_s     = HUNT;
                        match_cnt_s = 4'd0;
                    end
                end
                LOCKED: begin
                    data_s  = sr_next_s;
                    valid_s = 1'b1;
                end
                default: begin
                    state_s     = HUNT;
                    match_cnt_s = 4'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Serial shift register and align-level history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_r      <= '0;
            align_d_r <= 1'b0;
        end else begin
            sr_r      <= sr_next_s;
            align_d_r <= rx_data_align;
        end
    end

    // Bit counter with single-edge hold on slip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r   <= 3'd0;
            slip_pend_r <= 1'b0;
        end else if (slip_s) begin
            bit_cnt_r   <= bit_cnt_r;
            slip_pend_r <= 1'b1;
        end else begin
            bit_cnt_r   <= bit_cnt_r + 3'd1;
            slip_pend_r <= 1'b0;
        end
    end

    // FSM state and match counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= HUNT;
            match_cnt_r <= 4'd0;
        end else begin
            state_r     <= state_s;
            match_cnt_r <= match_cnt_s;
        end
    end

    // Registered outputs; lock flag mirrors the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_locked <= 1'b0;
        end else begin
            rx_data   <= data_s;
            rx_valid  <= valid_s;
            rx_locked <= (state_s == LOCKED);
        end
    end

`ifdef LVDS_RX_SLIP_POS_EN
    logic [2:0] slip_pos_r;

    // Slip position counter, cleared on re-hunt; holds naturally once locked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slip_pos_r <= 3'd0;
        end else if (align_rise_s) begin
            slip_pos_r <= 3'd0;
        end else if (slip_s) begin
            slip_pos_r <= slip_pos_r + 3'd1;
        end else begin
            slip_pos_r <= slip_pos_r;
        end
    end

    assign rx_slip_pos = slip_pos_r;
`endif

endmodule

// File: tb/tb_lvds_rx_deser.sv
// Directed self-checking bench for lvds_rx_deser: reset, aligned lock, offset lock, broken verify, re-hunt.
module tb_lvds_rx_deser;

    logic       clk;
    logic       rst_n;
    logic       rx_in;
    logic       rx_data_align;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_locked;
`ifdef LVDS_RX_SLIP_POS_EN
    logic [2:0] rx_slip_pos;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int edge_n = 0;

    lvds_rx_deser dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_in         (rx_in),
        .rx_data_align (rx_data_align),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_locked     (rx_locked)
`ifdef LVDS_RX_SLIP_POS_EN
        ,
        .rx_slip_pos   (rx_slip_pos)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, edge_n, obs, exp);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        rx_in         = 1'b0;
        rx_data_align = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        edge_n = 0;
    endtask

    // Drive one bit (and align level), clock it in, sample 1 time unit after the edge.
    task automatic step(input logic b, input logic al);
        rx_in         = b;
        rx_data_align = al;
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    logic [7:0] pat;
    logic [7:0] al_words [7];
    logic [7:0] w;
    logic       exp_v;
    logic       exp_l;
    logic       al;
    int         ns;

    initial begin
        pat = 8'hF1;
        al_words[0] = 8'hF1; al_words[1] = 8'hF1; al_words[2] = 8'hF1; al_words[3] = 8'hF1;
        al_words[4] = 8'h22; al_words[5] = 8'hF1; al_words[6] = 8'h22;

        // Reset held while rx_in toggles
        rst_n         = 1'b0;
        rx_in         = 1'b0;
        rx_data_align = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rx_in = i[0];
            @(posedge clk);
            #1;
            check_eq("rst_data", 32'(rx_data), 32'h00);
            check_eq("rst_valid", 32'(rx_valid), 32'h0);
            check_eq("rst_locked", 32'(rx_locked), 32'h0);
        end

        // Aligned lock then payload
        do_reset();
        for (int wi = 0; wi < 7; wi++) begin
            for (int b = 7; b >= 0; b--) begin
                w = al_words[wi];
                step(w[b], 1'b0);
                exp_v = (edge_n == 40) || (edge_n == 48) || (edge_n == 56);
                check_eq("al_valid", 32'(rx_valid), 32'(exp_v));
                check_eq("al_locked", 32'(rx_locked), 32'(edge_n >= 32));
                if (exp_v) check_eq("al_data", 32'(rx_data), 32'(al_words[edge_n / 8 - 1]));
`ifdef LVDS_RX_SLIP_POS_EN
                check_eq("al_slip", 32'(rx_slip_pos), 32'd0);
`endif
            end
        end
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check_eq("pre_rst_data", 32'(rx_data), 32'h22);
        // Asynchronous reset mid-word, checked before any further edge
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_data", 32'(rx_data), 32'h00);
        check_eq("async_valid", 32'(rx_valid), 32'h0);
        check_eq("async_locked", 32'(rx_locked), 32'h0);

        // Offset lock: 3 zero bits then repeated training word
        do_reset();
        for (int e = 1; e <= 83; e++) begin
            if (e <= 3) step(1'b0, 1'b0);
            else step(pat[7 - ((e - 4) % 8)], 1'b0);
            exp_v = (edge_n >= 67) && ((edge_n - 67) % 8 == 0);
            check_eq("off_valid", 32'(rx_valid), 32'(exp_v));
            check_eq("off_locked", 32'(rx_locked), 32'(edge_n >= 59));
            if (exp_v) check_eq("off_data", 32'(rx_data), 32'hF1);
`ifdef LVDS_RX_SLIP_POS_EN
            ns = (edge_n >= 26) ? 3 : (edge_n >= 17) ? 2 : (edge_n >= 8) ? 1 : 0;
            check_eq("off_slip", 32'(rx_slip_pos), 32'(ns));
`endif
        end

        // Broken verify: third word corrupted, realign needs 8 slips
        do_reset();
        for (int e = 1; e <= 140; e++) begin
            w = (((e - 1) / 8) == 2) ? 8'hF0 : 8'hF1;
            step(w[7 - ((e - 1) % 8)], 1'b0);
            exp_v = (edge_n >= 128) && ((edge_n - 128) % 8 == 0);
            check_eq("brk_valid", 32'(rx_valid), 32'(exp_v));
            check_eq("brk_locked", 32'(rx_locked), 32'(edge_n >= 120));
            if (exp_v) check_eq("brk_data", 32'(rx_data), 32'hF1);
`ifdef LVDS_RX_SLIP_POS_EN
            ns = (edge_n < 24) ? 0 : (((edge_n - 24) / 9 + 1) > 8 ? 8 : ((edge_n - 24) / 9 + 1));
            check_eq("brk_slip", 32'(rx_slip_pos), 32'(ns % 8));
`endif
        end

        // Re-hunt mid-word, then align rise coincident with a boundary
        do_reset();
        for (int e = 1; e <= 140; e++) begin
            al = ((e >= 45) && (e <= 84)) || (e >= 96);
            step(pat[7 - ((e - 1) % 8)], al);
            exp_l = ((edge_n >= 32) && (edge_n < 45)) || ((edge_n >= 72) && (edge_n < 96)) || (edge_n >= 128);
            exp_v = (edge_n == 40) || (edge_n == 80) || (edge_n == 88) || (edge_n == 136);
            check_eq("rh_valid", 32'(rx_valid), 32'(exp_v));
            check_eq("rh_locked", 32'(rx_locked), 32'(exp_l));
            if (exp_v) check_eq("rh_data", 32'(rx_data), 32'hF1);
`ifdef LVDS_RX_SLIP_POS_EN
            check_eq("rh_slip", 32'(rx_slip_pos), 32'd0);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
